hilo_muldiv_unit: RTL

- Multi-cycle HI/LO multiply/divide unit in the execute path, directly downstream of the control decoder.
- Consumes the decoder's decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with register-file operands, and owns the HI and LO architectural registers.
- Drives the decoder's stall input so EXEC_1 holds until a long operation completes.
- HI/LO are exposed for MFHI/MFLO writeback through the ALU result mux.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/hilo_div_step.sv | 20 ++
 rtl/hilo_muldiv_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS encodings and HI/LO multiply/divide types
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL   = 6'b000000,
        F_MFHI  = 6'b010000,
        F_MTHI  = 6'b010001,
        F_MFLO  = 6'b010010,
        F_MTLO  = 6'b010011,
        F_MULT  = 6'b011000,
        F_MULTU = 6'b011001,
        F_DIV   = 6'b011010,
        F_DIVU  = 6'b011011,
        F_ADD   = 6'b100000,
        F_SUB   = 6'b100010,
        F_AND   = 6'b100100,
        F_OR    = 6'b100101,
        F_SLT   = 6'b101010
    } rtype_t;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/hilo_div_step.sv
// rtl/hilo_div_step.sv - one restoring-division step over unsigned magnitudes
module hilo_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN:0]   divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0] trial;
    logic          take;

    assign trial = {rem, quo[XLEN-1]};
    assign take  = (trial >= divisor);
    // The difference is always below the divisor, so the low XLEN bits are exact.
    assign rem_next = take ? (trial[XLEN-1:0] - divisor[XLEN-1:0]) : trial[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], take};

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - multi-cycle HI/LO multiply/divide unit with decoder stall
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    md_state_t       state, state_next;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   mag_a, mag_b, abs_a, abs_b;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0] rem, rem_next, quo_next;
    logic [XLEN:0]   mul_sum;
    logic            neg_q, neg_rem_q, div_zero_q, div_q, sgn, long_op;

    assign sgn     = is_signed_op(op);
    assign long_op = is_long_op(op);
    // Magnitudes carry an extra bit so |0x80000000| is held without truncation.
    assign abs_a = (sgn && srcA[XLEN-1]) ? -{1'b1, srcA} : {1'b0, srcA};
    assign abs_b = (sgn && srcB[XLEN-1]) ? -{1'b1, srcB} : {1'b0, srcB};
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? mag_a : '0);

    assign busy  = (state != IDLE);
    assign stall = busy || (start && long_op && (state == IDLE));

    hilo_div_step #(.XLEN(XLEN)) u_div_step (
        .rem      (rem),
        .quo      (acc[XLEN-1:0]),
        .divisor  (mag_b),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start && long_op)
                      state_next = ((op == MD_MULT) || (op == MD_MULTU)) ? MUL : DIV;
            MUL, DIV: if (cnt == LAST) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            hi         <= '0;
            lo         <= '0;
            acc        <= '0;
            rem        <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            div_q      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    if (op == MD_MTHI) begin
                        hi <= srcA;
                    end else if (op == MD_MTLO) begin
                        lo <= srcA;
                    end else if (long_op) begin
                        mag_a      <= abs_a;
                        mag_b      <= abs_b;
                        neg_q      <= sgn && (srcA[XLEN-1] ^ srcB[XLEN-1]);
                        neg_rem_q  <= sgn && srcA[XLEN-1];
                        div_zero_q <= (srcB == '0);
                        div_q      <= (op == MD_DIV) || (op == MD_DIVU);
                        // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
                        acc <= ((op == MD_DIV) || (op == MD_DIVU)) ? {{XLEN{1'b0}}, abs_a[XLEN-1:0]}
                                                                   : {{XLEN{1'b0}}, abs_b[XLEN-1:0]};
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[XLEN-1:1]};
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    acc[XLEN-1:0] <= quo_next;
                    rem           <= rem_next;
                    cnt           <= cnt + CW'(1);
                end
                FIX: begin
                    if (div_q) begin
                        hi <= neg_rem_q ? -rem : rem;
                        lo <= div_zero_q ? '1 : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
                    cnt  <= '0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
